// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO family: operation encodings and the width helper
// used to size memory indices and occupancy counters.
package stack_pkg;

    // Request encoding formed as {pop, push}
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_REPL = 2'b11
    } op_e;

    // Ceiling log2; returns 0 for values <= 1
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lifo_ptr_ctl.sv
// LIFO pointer control: occupancy counter, request accept/reject decode,
// sticky error flags and status decodes. Drives the memory write/read strobes.
module lifo_ptr_ctl
    import stack_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = DEPTH - 1,
    parameter int AW        = clog2(DEPTH),
    parameter int CW        = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          overflow,
    output logic          underflow,
    output logic          wr_en,
    output logic [AW-1:0] wr_idx,
    output logic          rd_en,
    output logic [AW-1:0] rd_idx
);

    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;

    op_e           w_op;
    logic          w_nonempty;
    logic          w_full;
    logic [AW-1:0] w_top_idx;
    logic [CW-1:0] w_count_nxt;
    logic          w_set_ovf;
    logic          w_set_unf;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_idx;
    logic          w_rd_en;

    assign w_op       = op_e'({pop, push});
    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_top_idx  = AW'(r_count - CW'(1));

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_idx    = AW'(r_count);
        w_rd_en     = 1'b0;
        w_count_nxt = r_count;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        if (!clear) begin
            case (w_op)
                OP_PUSH: begin
                    if (!w_full) begin
                        w_wr_en     = 1'b1;
                        w_count_nxt = r_count + CW'(1);
                    end else begin
                        w_set_ovf   = 1'b1;
                    end
                end
                OP_POP: begin
                    if (w_nonempty) begin
                        w_rd_en     = 1'b1;
                        w_count_nxt = r_count - CW'(1);
                    end else begin
                        w_set_unf   = 1'b1;
                    end
                end
                OP_REPL: begin
                    // Replace-top keeps occupancy; on an empty stack only the push lands
                    if (w_nonempty) begin
                        w_rd_en     = 1'b1;
                        w_wr_en     = 1'b1;
                        w_wr_idx    = w_top_idx;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_wr_idx    = '0;
                        w_count_nxt = CW'(1);
                        w_set_unf   = 1'b1;
                    end
                end
                default: begin
                    w_wr_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_overflow  <= r_overflow | w_set_ovf;
            r_underflow <= r_underflow | w_set_unf;
        end
    end

    assign count       = r_count;
    assign empty       = ~w_nonempty;
    assign full        = w_full;
    assign almost_full = (r_count >= CW'(AFULL_LVL));
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign wr_en       = w_wr_en;
    assign wr_idx      = w_wr_idx;
    assign rd_en       = w_rd_en;
    assign rd_idx      = w_top_idx;

endmodule

// File: rtl/param_lifo.sv
// Parametrised LIFO: storage array, registered pop data with valid strobe and a
// combinational top-of-stack view; pointer control lives in lifo_ptr_ctl.
module param_lifo
    import stack_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = DEPTH - 1,
    localparam int AW       = clog2(DEPTH),
    localparam int CW       = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;
    logic             w_rd_en;
    logic [AW-1:0]    w_rd_idx;
    logic [CW-1:0]    w_count;
    logic             w_empty;

    lifo_ptr_ctl #(
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL),
        .AW        (AW),
        .CW        (CW)
    ) u_ptr_ctl (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .push        (push),
        .pop         (pop),
        .count       (w_count),
        .empty       (w_empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow),
        .wr_en       (w_wr_en),
        .wr_idx      (w_wr_idx),
        .rd_en       (w_rd_en),
        .rd_idx      (w_rd_idx)
    );

    // Storage is deliberately not reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    // Read samples the pre-write word, so replace-top returns the old top
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_rd_data <= r_mem[w_rd_idx];
            end
        end
    end

    assign top      = w_empty ? '0 : r_mem[w_rd_idx];
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign count    = w_count;
    assign empty    = w_empty;

endmodule

// File: tb/tb_param_lifo.sv
// Self-checking bench for param_lifo (WIDTH=8, DEPTH=4, AFULL_LVL=3): directed
// steps followed by random traffic, all compared against a queue-based model.
module tb_param_lifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clear = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_rd_data = '0;
    logic             m_rd_valid = 1'b0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    param_lifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .top         (top),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
    endtask

    task automatic model_step(input logic c, input logic pu, input logic po, input logic [WIDTH-1:0] d);
        m_rd_valid = 1'b0;
        if (c) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (pu && po) begin
            if (m_q.size() > 0) begin
                m_rd_data  = m_q[m_q.size()-1];
                m_rd_valid = 1'b1;
                m_q[m_q.size()-1] = d;
            end else begin
                m_q.push_back(d);
                m_unf = 1'b1;
            end
        end else if (pu) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
        end else if (po) begin
            if (m_q.size() > 0) begin
                m_rd_data  = m_q.pop_back();
                m_rd_valid = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [WIDTH-1:0] exp_top;
        n = m_q.size();
        exp_top = (n > 0) ? m_q[n-1] : '0;
        chk({tag, ".count"},    32'(count),       32'(n));
        chk({tag, ".empty"},    32'(empty),       32'(n == 0));
        chk({tag, ".full"},     32'(full),        32'(n == DEPTH));
        chk({tag, ".afull"},    32'(almost_full), 32'(n >= AFULL));
        chk({tag, ".top"},      32'(top),         32'(exp_top));
        chk({tag, ".rd_data"},  32'(rd_data),     32'(m_rd_data));
        chk({tag, ".rd_valid"}, 32'(rd_valid),    32'(m_rd_valid));
        chk({tag, ".overflow"}, 32'(overflow),    32'(m_ovf));
        chk({tag, ".underflow"},32'(underflow),   32'(m_unf));
    endtask

    // One clock: present request, take the edge, update model, compare
    task automatic step(input string tag, input logic c, input logic pu, input logic po,
                        input logic [WIDTH-1:0] d);
        clear   = c;
        push    = pu;
        pop     = po;
        data_in = d;
        @(posedge clk);
        #1;
        model_step(c, pu, po, d);
        clear = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        check_all(tag);
    endtask

    initial begin
        // Reset and idle
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all("reset");
        step("idle", 1'b0, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset mid-stream with two entries
        step("pre_rst_a", 1'b0, 1'b1, 1'b0, 8'hE1);
        step("pre_rst_b", 1'b0, 1'b1, 1'b0, 8'hE2);
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        #1 rst = 1'b1;

        // Fill, almost-full, full, dropped push
        step("push11", 1'b0, 1'b1, 1'b0, 8'h11);
        step("push22", 1'b0, 1'b1, 1'b0, 8'h22);
        step("push33", 1'b0, 1'b1, 1'b0, 8'h33);
        chk("afull_at3", 32'(almost_full), 32'd1);
        chk("top33", 32'(top), 32'h33);
        step("push44", 1'b0, 1'b1, 1'b0, 8'h44);
        step("push55_drop", 1'b0, 1'b1, 1'b0, 8'h55);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("top44_after_drop", 32'(top), 32'h44);

        // Drain in reverse order, then underflow
        step("pop1", 1'b0, 1'b0, 1'b1, 8'h00);
        chk("pop1_data", 32'(rd_data), 32'h44);
        step("pop2", 1'b0, 1'b0, 1'b1, 8'h00);
        step("pop3", 1'b0, 1'b0, 1'b1, 8'h00);
        step("pop4", 1'b0, 1'b0, 1'b1, 8'h00);
        chk("pop4_data", 32'(rd_data), 32'h11);
        step("pop5_under", 1'b0, 1'b0, 1'b1, 8'h00);
        chk("hold_rd_data", 32'(rd_data), 32'h11);

        // Replace-top mid-stack and at full
        step("clr1", 1'b1, 1'b0, 1'b0, 8'h00);
        step("pushA0", 1'b0, 1'b1, 1'b0, 8'hA0);
        step("pushB0", 1'b0, 1'b1, 1'b0, 8'hB0);
        step("replC0", 1'b0, 1'b1, 1'b1, 8'hC0);
        chk("repl_rd", 32'(rd_data), 32'hB0);
        chk("repl_top", 32'(top), 32'hC0);
        step("pushD0", 1'b0, 1'b1, 1'b0, 8'hD0);
        step("pushE0", 1'b0, 1'b1, 1'b0, 8'hE0);
        step("repl_full", 1'b0, 1'b1, 1'b1, 8'hF0);
        chk("repl_full_noovf", 32'(overflow), 32'd0);

        // Push+pop on empty
        step("clr2", 1'b1, 1'b0, 1'b0, 8'h00);
        step("repl_empty", 1'b0, 1'b1, 1'b1, 8'h5A);
        chk("repl_empty_top", 32'(top), 32'h5A);

        // Clear beats a simultaneous push
        step("fill_b", 1'b0, 1'b1, 1'b0, 8'h61);
        step("fill_c", 1'b0, 1'b1, 1'b0, 8'h62);
        step("fill_d", 1'b0, 1'b1, 1'b0, 8'h63);
        step("fill_ovf", 1'b0, 1'b1, 1'b0, 8'h64);
        step("pop_to3", 1'b0, 1'b0, 1'b1, 8'h00);
        step("clr_push", 1'b1, 1'b1, 1'b0, 8'h99);
        step("push77", 1'b0, 1'b1, 1'b0, 8'h77);
        chk("top77", 32'(top), 32'h77);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic c;
            logic pu;
            logic po;
            logic [WIDTH-1:0] d;
            c  = ($urandom_range(0, 29) == 0);
            pu = $urandom_range(0, 1) == 1;
            po = $urandom_range(0, 1) == 1;
            d  = WIDTH'($urandom);
            step("rand", c, pu, po, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
